calc_driver: RTL and testbench

CALC_DRIVER -- requirements
Module: calc_driver

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/calc_press_gen.sv | 29 ++
 rtl/calc_driver.sv | 182 ++++++++++++++++++
 tb/tb_calc_driver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-panel driver.
// The driver keys operands into a calculator through its switch/enter inputs.
package calc_pkg;

    localparam int C_DATA_WIDTH      = 16;
    localparam int C_OPCODE_WIDTH    = 2;
    localparam int C_CNT_WIDTH       = 16;
    localparam int C_DEBOUNCE_CYCLES = 10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PRESS,
        RELEASE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        STEP_A,
        STEP_B,
        STEP_OP,
        STEP_WRAP
    } step_t;

    function automatic logic [C_DATA_WIDTH-1:0] step_value(
        input step_t                     step,
        input logic [C_DATA_WIDTH-1:0]   a,
        input logic [C_DATA_WIDTH-1:0]   b,
        input logic [C_OPCODE_WIDTH-1:0] op
    );
        logic [C_DATA_WIDTH-1:0] v;
        case (step)
            STEP_A:  v = a;
            STEP_B:  v = b;
            STEP_OP: v = {{(C_DATA_WIDTH-C_OPCODE_WIDTH){1'b0}}, op};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/calc_press_gen.sv
// Phase timer: loads a cycle count on start, flags the final cycle of the phase.
// The count sits at zero when idle so o_done is high between phases.
module calc_press_gen
    import calc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [C_CNT_WIDTH-1:0] i_len,
    output logic                   o_done
);

    localparam logic [C_CNT_WIDTH-1:0] L_ONE = C_CNT_WIDTH'(1);

    logic [C_CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_len - L_ONE;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - L_ONE;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/calc_driver.sv
// Drives A, B, opcode and a wrap press into the calculator,
// then returns the captured display and flags over a valid/ready port.
module calc_driver
    import calc_pkg::*;
#(
    parameter int C_SETTLE_CYCLES  = 4,
    parameter int C_PRESS_CYCLES   = 16,
    parameter int C_RELEASE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [C_DATA_WIDTH-1:0]   req_a,
    input  logic [C_DATA_WIDTH-1:0]   req_b,
    input  logic [C_OPCODE_WIDTH-1:0] req_opcode,
    output logic [C_DATA_WIDTH-1:0]   value,
    output logic                      enter,
    output logic                      undo,
    input  logic [C_DATA_WIDTH-1:0]   display,
    input  logic [3:0]                flags,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [C_DATA_WIDTH-1:0]   rsp_result,
    output logic [3:0]                rsp_flags,
    output logic                      busy
);

    localparam logic [C_CNT_WIDTH-1:0] L_SETTLE  = C_CNT_WIDTH'(C_SETTLE_CYCLES);
    localparam logic [C_CNT_WIDTH-1:0] L_PRESS   = C_CNT_WIDTH'(C_PRESS_CYCLES);
    localparam logic [C_CNT_WIDTH-1:0] L_RELEASE = C_CNT_WIDTH'(C_RELEASE_CYCLES);

    if (C_SETTLE_CYCLES < 2 || C_SETTLE_CYCLES >= 2**C_CNT_WIDTH) begin : g_bad_settle
        $error("C_SETTLE_CYCLES out of range");
    end
    if (C_PRESS_CYCLES <= C_DEBOUNCE_CYCLES || C_PRESS_CYCLES >= 2**C_CNT_WIDTH) begin : g_bad_press
        $error("C_PRESS_CYCLES must exceed the debouncer delay");
    end
    if (C_RELEASE_CYCLES <= C_DEBOUNCE_CYCLES || C_RELEASE_CYCLES >= 2**C_CNT_WIDTH) begin : g_bad_release
        $error("C_RELEASE_CYCLES must exceed the debouncer delay");
    end

    state_t                    r_state;
    step_t                     r_step;
    logic [C_DATA_WIDTH-1:0]   r_a;
    logic [C_DATA_WIDTH-1:0]   r_b;
    logic [C_OPCODE_WIDTH-1:0] r_op;
    logic [C_DATA_WIDTH-1:0]   r_value;
    logic                      r_enter;
    logic                      r_busy;
    logic                      r_req_ready;
    logic                      r_rsp_valid;
    logic [C_DATA_WIDTH-1:0]   r_rsp_result;
    logic [3:0]                r_rsp_flags;

    logic                      w_done;
    logic                      w_start;
    logic [C_CNT_WIDTH-1:0]    w_len;
    step_t                     w_step_nxt;

    assign w_step_nxt = step_t'(r_step + 2'd1);

    // Reload the timer on every phase transition with the next phase length.
    always_comb begin
        w_start = 1'b0;
        w_len   = L_SETTLE;
        case (r_state)
            IDLE: begin
                w_start = req_valid;
                w_len   = L_SETTLE;
            end
            SETUP: begin
                w_start = w_done;
                w_len   = L_PRESS;
            end
            PRESS: begin
                w_start = w_done;
                w_len   = L_RELEASE;
            end
            RELEASE: begin
                w_start = w_done && (r_step != STEP_WRAP);
                w_len   = L_SETTLE;
            end
            default: begin
                w_start = 1'b0;
                w_len   = L_SETTLE;
            end
        endcase
    end

    calc_press_gen u_press_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_len   (w_len),
        .o_done  (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_step       <= STEP_A;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_value      <= '0;
            r_enter      <= 1'b0;
            r_busy       <= 1'b0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a         <= req_a;
                        r_b         <= req_b;
                        r_op        <= req_opcode;
                        r_step      <= STEP_A;
                        r_value     <= req_a;
                        r_busy      <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_done) begin
                        // Calculator still shows the result before the wrap press.
                        if (r_step == STEP_WRAP) begin
                            r_rsp_result <= display;
                            r_rsp_flags  <= flags;
                        end
                        r_enter <= 1'b1;
                        r_state <= PRESS;
                    end
                end
                PRESS: begin
                    if (w_done) begin
                        r_enter <= 1'b0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_done) begin
                        if (r_step == STEP_WRAP) begin
                            r_value     <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_step  <= w_step_nxt;
                            r_value <= step_value(w_step_nxt, r_a, r_b, r_op);
                            r_state <= SETUP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_step      <= STEP_A;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign value      = r_value;
    assign enter      = r_enter;
    assign undo       = 1'b0;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign busy       = r_busy;

endmodule

// File: tb/tb_calc_driver.sv
// Bench for calc_driver: random requests against a cycle-indexed model
// of the four-press key sequence and the result capture point.
module tb_calc_driver;

    localparam int S     = 4;
    localparam int P     = 16;
    localparam int R     = 16;
    localparam int STEP  = S + P + R;
    localparam int TOTAL = 4 * STEP;
    localparam int CAP   = 3 * STEP + S;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [1:0]  req_opcode = '0;
    logic [15:0] display = '0;
    logic [3:0]  flags = '0;

    logic        req_ready;
    logic [15:0] value;
    logic        enter;
    logic        undo;
    logic        rsp_valid;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;

    int checks = 0;
    int failures = 0;

    calc_driver #(
        .C_SETTLE_CYCLES  (S),
        .C_PRESS_CYCLES   (P),
        .C_RELEASE_CYCLES (R)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_opcode (req_opcode),
        .value      (value),
        .enter      (enter),
        .undo       (undo),
        .display    (display),
        .flags      (flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: sim time exceeded, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // One full operation; on entry we sit at a negedge with the DUT idle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input bit rand_disp,
                          input int hold, input bit hold_valid);
        logic [15:0] opnd [4];
        logic [15:0] exp_res;
        logic [3:0]  exp_flg;
        logic [20:0] obs;
        logic [20:0] expv;
        int          rises;
        logic        prev;
        int          o;
        int          k;
        opnd[0] = a;
        opnd[1] = b;
        opnd[2] = {14'd0, op};
        opnd[3] = 16'h0000;
        exp_res = display;
        exp_flg = flags;
        req_a = a;
        req_b = b;
        req_opcode = op;
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: got %b want 1", req_ready);
        end
        rises = 0;
        prev = 1'b0;
        for (int t = 1; t <= TOTAL + 1; t++) begin
            @(negedge clk);
            if (t <= TOTAL) begin
                o = (t - 1) % STEP;
                k = (t - 1) / STEP;
                expv = {(o >= S && o < S + P), 1'b1, 1'b0, 1'b0, 1'b0, opnd[k]};
            end else begin
                expv = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
            end
            obs = {enter, busy, rsp_valid, req_ready, undo, value};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL wave t=%0d {enter,busy,rsp_valid,req_ready,undo,value}: got %h want %h",
                         t, obs, expv);
            end
            if (enter === 1'b1 && prev !== 1'b1) rises++;
            prev = enter;
            if (t == TOTAL + 1) begin
                checks++;
                if (rsp_result !== exp_res || rsp_flags !== exp_flg) begin
                    failures++;
                    $display("FAIL result: got %h/%h want %h/%h",
                             rsp_result, rsp_flags, exp_res, exp_flg);
                end
                req_valid = hold_valid;
            end else begin
                req_valid = 1'($urandom);
            end
            req_a = 16'($urandom);
            req_b = 16'($urandom);
            req_opcode = 2'($urandom);
            if (rand_disp) begin
                display = 16'($urandom);
                flags = 4'($urandom);
            end
            if (t == CAP) begin
                exp_res = display;
                exp_flg = flags;
            end
        end
        checks++;
        if (rises != 4) begin
            failures++;
            $display("FAIL enter_pulses: got %0d want 4", rises);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, req_ready, busy, enter} !== 4'b1010 ||
                rsp_result !== exp_res || rsp_flags !== exp_flg) begin
                failures++;
                $display("FAIL hold h=%0d: got v=%b rdy=%b busy=%b en=%b res=%h/%h want 1 0 1 0 %h/%h",
                         h, rsp_valid, req_ready, busy, enter, rsp_result, rsp_flags,
                         exp_res, exp_flg);
            end
            display = 16'($urandom);
            flags = 4'($urandom);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, busy, enter} !== 4'b0100 || value !== 16'h0000) begin
            failures++;
            $display("FAIL after_handshake: got v=%b rdy=%b busy=%b en=%b value=%h want 0 1 0 0 0000",
                     rsp_valid, req_ready, busy, enter, value);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({enter, undo, busy, rsp_valid, req_ready} !== 5'b00001 ||
            value !== 16'h0 || rsp_result !== 16'h0 || rsp_flags !== 4'h0) begin
            failures++;
            $display("FAIL reset_state: got en=%b undo=%b busy=%b v=%b rdy=%b value=%h res=%h/%h want 0 0 0 0 1 0 0/0",
                     enter, undo, busy, rsp_valid, req_ready, value, rsp_result, rsp_flags);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b busy=%b want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_basic();
        display = 16'hBEEF;
        flags = 4'hA;
        run_op(16'h0001, 16'h0002, 2'd3, 1'b0, 0, 1'b0);
        checks++;
        if (rsp_result !== 16'hBEEF || rsp_flags !== 4'hA) begin
            failures++;
            $display("FAIL basic_result: got %h/%h want beef/a", rsp_result, rsp_flags);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 16'($urandom), 2'($urandom), 1'b1,
                   int'($urandom_range(0, 5)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_op(16'($urandom), 16'($urandom), 2'($urandom), 1'b1, 50, 1'b1);
        run_op(16'hFFFF, 16'h0000, 2'd0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        req_opcode = 2'($urandom);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int t = 2; t <= STEP + S + 5; t++) @(negedge clk);
        checks++;
        if (enter !== 1'b1 || value !== req_b) begin
            failures++;
            $display("FAIL mid_press: got en=%b value=%h want 1 %h", enter, value, req_b);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({enter, busy, rsp_valid, req_ready, undo} !== 5'b00010 || value !== 16'h0) begin
            failures++;
            $display("FAIL async_reset: got en=%b busy=%b v=%b rdy=%b undo=%b value=%h want 0 0 0 1 0 0000",
                     enter, busy, rsp_valid, req_ready, undo, value);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'($urandom), 16'($urandom), 2'($urandom), 1'b1, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
